// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-store loader: FSM encoding and byte-lane count.
package imem_loader_pkg;

  localparam int BYTE_LANES = 4;
  localparam int LANE_W     = $clog2(BYTE_LANES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction store, little-endian,
// holding the CPU until the final word lands. Overflow past MEM_BYTES aborts to ERROR.
// Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready is
// high only in ACCEPT, and in_word/in_last must be stable while in_valid is high.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 160,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded,
  output logic [2:0]       dbg_state
);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTE_LANES - 1);

  state_e            state_q, state_d;
  logic [63:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [23:0]       shift_q, shift_d;
  logic              last_q, last_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              mem_we_q, mem_we_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      words_q     <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      lane_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      words_q     <= words_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      lane_q      <= lane_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    words_d     = words_q;
    shift_d     = shift_q;
    last_d      = last_q;
    lane_d      = lane_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_ACCEPT;
          ptr_d   = '0;
          words_d = '0;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          // A full store means the word has nowhere to go: drop it and abort.
          if (ptr_q == 64'(MEM_BYTES)) begin
            state_d = S_ERROR;
          end else begin
            state_d     = S_WRITE;
            last_d      = in_last;
            lane_d      = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = in_word[7:0];
            shift_d     = in_word[31:8];
          end
        end
      end
      S_WRITE: begin
        // lane_q names the byte currently on the bus; the last lane retires the word.
        if (lane_q == LANE_LAST) begin
          ptr_d   = ptr_q + 64'(BYTE_LANES);
          words_d = words_q + CNT_W'(1);
          state_d = last_q ? S_DONE : S_ACCEPT;
        end else begin
          lane_d      = lane_q + LANE_W'(1);
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + 64'd1;
          mem_wdata_d = shift_q[7:0];
          shift_d     = {8'h00, shift_q[23:8]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_ACCEPT);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 160, SHALL give the instruction-store size in bytes (multiple of 4).
REQ-002 Parameter CNT_W, default 8, SHALL give the width of the word counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset (reset==0 sampled at a clk edge resets the block).
REQ-005 start  input  1  SHALL be a one-cycle request to begin loading at byte address 0.
REQ-006 in_valid  input  1  SHALL mark in_word and in_last as valid.
REQ-007 in_word  input  32  SHALL carry one RISC-V instruction word.
REQ-008 in_last  input  1  SHALL mark the final word of the program.
REQ-009 in_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-010 mem_we  output  1  SHALL be the byte write enable to the instruction store.
REQ-011 mem_addr  output  64  SHALL be the byte address of the write.
REQ-012 mem_wdata  output  8  SHALL be the byte written.
REQ-013 cpu_hold  output  1  SHALL hold the processor's PC/fetch while the store is incomplete.
REQ-014 done  output  1  SHALL flag a complete load.
REQ-015 error  output  1  SHALL flag an overflow abort.
REQ-016 words_loaded  output  CNT_W  SHALL count words fully written.

Function
REQ-017 FSM states SHALL be IDLE, ACCEPT, WRITE, DONE, ERROR.
REQ-018 IDLE: in_ready=0, mem_we=0; start=1 -> ACCEPT with address pointer=0 and words_loaded=0.
REQ-019 ACCEPT: in_ready=1; a word SHALL be accepted only on in_valid&in_ready; without in_valid the state holds indefinitely.
REQ-020 On acceptance, in_word and in_last SHALL be latched and the FSM SHALL enter WRITE with byte index 0.
REQ-021 WRITE: in_ready=0; mem_we=1 for exactly 4 consecutive cycles, bytes written little-endian: [7:0] at ptr, [15:8] at ptr+1, [23:16] at ptr+2, [31:24] at ptr+3.
REQ-022 mem_addr and mem_wdata SHALL be registered outputs, stable for the whole cycle in which mem_we=1.
REQ-023 After the 4th byte, ptr+=4 and words_loaded+=1 in the same cycle; next state DONE if latched last=1, else ACCEPT.
REQ-024 Throughput SHALL be one word per 5 cycles with in_valid held high.
REQ-025 Overflow: a word accepted with ptr==MEM_BYTES SHALL be dropped (no writes) and the FSM SHALL enter ERROR.
REQ-026 The word filling bytes MEM_BYTES-4..MEM_BYTES-1 SHALL be written normally and SHALL NOT raise error.
REQ-027 DONE: done=1, cpu_hold=0, in_ready=0; ERROR: error=1, cpu_hold=1, in_ready=0.
REQ-028 start in DONE or ERROR SHALL restart as in REQ-018 and clear done/error on the next cycle; start in ACCEPT or WRITE SHALL be ignored.
REQ-029 cpu_hold SHALL be 1 in every state except DONE.

Reset
REQ-030 On reset: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0.
REQ-031 Reset asserted mid-WRITE SHALL suppress mem_we from the following cycle; partial words SHALL NOT be completed.

Structure
REQ-032 State encoding and the byte-lane count (4) SHALL reside in a shared package used by the processor top level.
REQ-033 The block SHALL be a single module with no sub-modules; the byte-lane shift register and the FSM live in it.

Verification
REQ-034 Word 0x00800593, last=1 -> writes 0x93@0, 0x05@1, 0x80@2, 0x00@3 on consecutive cycles; done=1 and cpu_hold=0 the next cycle; words_loaded=1.
REQ-035 Two words 0x00000313, 0x00000393 with in_valid gaps of 3 cycles -> in_ready only in ACCEPT; bytes 0x13,0x03,0x00,0x00,0x93,0x03,0x00,0x00 at addresses 0..7.
REQ-036 40 words to MEM_BYTES=160, last on word 40 -> final write at address 159, done=1, error=0, words_loaded=40.
REQ-037 41 words, no last before word 41 -> word 41 produces no mem_we, error=1, cpu_hold=1, words_loaded=40.
REQ-038 reset=0 in the second WRITE cycle -> mem_we=0 from the next cycle, all outputs at reset values; a subsequent start reloads from address 0.
REQ-039 start pulsed during WRITE -> ignored; start pulsed in DONE -> done=0 next cycle, ptr=0, in_ready=1.
